// File: rtl/neural_bram_pkg.sv
// rtl/neural_bram_pkg.sv - shared requester indices, state encoding and grant helpers
//
// Requester map: REQ_RX_WR (0) UART RX writer, REQ_TX_RD (1) UART TX reader,
// REQ_PCPT (2) perceptron controller. Arbiter states: IDLE (no owner), OWNED.
package neural_bram_pkg;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] REQ_RX_WR = 2'd0;
    localparam logic [1:0] REQ_TX_RD = 2'd1;
    localparam logic [1:0] REQ_PCPT  = 2'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
        case (idx)
            REQ_RX_WR: return 3'b001;
            REQ_TX_RD: return 3'b010;
            REQ_PCPT:  return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

    // Input is one-hot-or-zero; zero maps to index 0, callers qualify with |oh.
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        if (oh[2]) return REQ_PCPT;
        if (oh[1]) return REQ_TX_RD;
        return REQ_RX_WR;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// rtl/bram_port_arbiter_if.sv - requester-side bus of the BRAM port arbiter
//
// master: requesters drive req/lock/we/addr/wdata, receive gnt/rvalid/rdata.
// slave:  the arbiter side of the same bundle.
// Slices are packed per requester: we[i*NB +: NB], addr[i*ADDR_W +: ADDR_W],
// wdata[i*DATA_W +: DATA_W].
interface bram_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) ();
    import neural_bram_pkg::*;

    localparam int NB = DATA_W / 8;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*NB-1:0]     we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - three-way round-robin picker
//
// Ports: req (requests), ptr (last granted index), mask (temporarily
// ineligible requesters) -> gnt (one-hot-or-zero). Search starts at
// (ptr+1) mod 3; ptr value 3 is never produced and behaves like 2.
module rr_pick3
    import neural_bram_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] gnt
);

    logic [NUM_REQ-1:0] elig;

    always_comb begin
        elig = req & ~mask;
        gnt  = '0;
        case (ptr)
            2'd0: begin
                if      (elig[1]) gnt = 3'b010;
                else if (elig[2]) gnt = 3'b100;
                else if (elig[0]) gnt = 3'b001;
            end
            2'd1: begin
                if      (elig[2]) gnt = 3'b100;
                else if (elig[0]) gnt = 3'b001;
                else if (elig[1]) gnt = 3'b010;
            end
            default: begin
                if      (elig[0]) gnt = 3'b001;
                else if (elig[1]) gnt = 3'b010;
                else if (elig[2]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - three-requester arbiter for one BRAM port
//
// Ports: clk, rst_n (async, active-low); bus (slave side of
// bram_port_arbiter_if: req/lock/we/addr/wdata in, gnt/rvalid/rdata out);
// bram_en/bram_we/bram_addr/bram_din drive the BRAM, bram_dout returns read
// data one cycle after the access.
// Optional macro BRAM_ARB_HOLD_LIMIT_EN: caps a locked burst at MAX_HOLD
// cycles while another requester waits; without it a lock holds indefinitely.
module bram_port_arbiter
    import neural_bram_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    bram_port_arbiter_if.slave  bus,
    output logic                bram_en,
    output logic [DATA_W/8-1:0] bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_din,
    input  logic [DATA_W-1:0]   bram_dout
);

    localparam int NB = DATA_W / 8;

    arb_state_t         state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         gidx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] rd_pend_q, rd_pend_d;
    logic               lock_g;
    logic [NB-1:0]      mux_we;
    logic [ADDR_W-1:0]  mux_addr;
    logic [DATA_W-1:0]  mux_din;

`ifdef BRAM_ARB_HOLD_LIMIT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;

    // A requester that just lost a forced release sits out exactly one cycle.
    assign mask = mask_q;
`else
    assign mask = '0;

    // MAX_HOLD has no effect in this build; the parameter is kept so both
    // builds share one instantiation.
    if (MAX_HOLD != 0) begin : g_max_hold_ignored
    end
`endif

    rr_pick3 u_pick (
        .req  (bus.req),
        .ptr  (ptr_q),
        .mask (mask),
        .gnt  (pick_gnt)
    );

    // A locked owner that still requests bypasses the pointer; otherwise
    // round-robin. Grant is forced low while reset is held.
    always_comb begin
        gnt = '0;
        if (rst_n) begin
            if (state_q == OWNED && |(bus.req & idx_to_onehot(owner_q)))
                gnt = idx_to_onehot(owner_q);
            else
                gnt = pick_gnt;
        end
    end

    assign gidx   = onehot_to_idx(gnt);
    assign lock_g = |(bus.lock & gnt);

    always_comb begin
        mux_we   = '0;
        mux_addr = '0;
        mux_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mux_we   = bus.we[i*NB +: NB];
                mux_addr = bus.addr[i*ADDR_W +: ADDR_W];
                mux_din  = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = IDLE;
        owner_d = 2'd0;
        ptr_d   = ptr_q;
        if (|gnt) begin
            ptr_d = gidx;
            if (lock_g) begin
                state_d = OWNED;
                owner_d = gidx;
            end
        end
`ifdef BRAM_ARB_HOLD_LIMIT_EN
        hold_d = '0;
        mask_d = '0;
        // Only a continuing burst accumulates hold time; a fresh lock starts at 0.
        if (state_q == OWNED && state_d == OWNED && gidx == owner_q) begin
            hold_d = hold_q;
            if (|(bus.req & ~gnt)) begin
                if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d = IDLE;
                    owner_d = 2'd0;
                    mask_d  = gnt;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
        end
`endif
        // Reads are granted accesses with an all-zero byte-enable slice.
        rd_pend_d = (mux_we == '0) ? gnt : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 2'd0;
            ptr_q     <= REQ_PCPT;
            rd_pend_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            rd_pend_q <= rd_pend_d;
        end
    end

`ifdef BRAM_ARB_HOLD_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            mask_q <= '0;
        end else begin
            hold_q <= hold_d;
            mask_q <= mask_d;
        end
    end
`endif

    assign bus.gnt    = gnt;
    assign bus.rvalid = rd_pend_q;
    assign bus.rdata  = (|rd_pend_q) ? bram_dout : '0;

    assign bram_en   = |gnt;
    assign bram_we   = mux_we;
    assign bram_addr = mux_addr;
    assign bram_din  = mux_din;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed self-checking bench for bram_port_arbiter
module tb_bram_port_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int NB     = DATA_W / 8;

    logic              clk;
    logic              rst_n;
    logic              bram_en;
    logic [NB-1:0]     bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first BRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < NB; b++)
                if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
            bram_dout <= mem[bram_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [NB-1:0] w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        bus.we[i*NB +: NB]            = w;
        bus.addr[i*ADDR_W +: ADDR_W]  = a;
        bus.wdata[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.req   = '0;
        bus.lock  = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;

        // Reset values, with requests already present
        repeat (2) @(posedge clk);
        bus.req = 3'b111;
        #1;
        chk("rst_gnt",     bus.gnt,    3'b000);
        chk("rst_rvalid",  bus.rvalid, 3'b000);
        chk("rst_rdata",   bus.rdata,  32'h0);
        chk("rst_bram_en", bram_en,    1'b0);
        chk("rst_bram_we", bram_we,    4'h0);
        bus.req = '0;
        tick();
        rst_n = 1'b1;

        // Round robin from reset pointer: 0, 1, 2
        bus.req = 3'b111;
        @(negedge clk); chk("rr_0", bus.gnt, 3'b001);
        tick();
        @(negedge clk); chk("rr_1", bus.gnt, 3'b010);
        chk("rr_rv0", bus.rvalid, 3'b001);
        tick();
        @(negedge clk); chk("rr_2", bus.gnt, 3'b100);
        chk("rr_rv1", bus.rvalid, 3'b010);
        tick();
        bus.req = '0;
        @(negedge clk); chk("rr_rv2", bus.rvalid, 3'b100);
        chk("idle_gnt", bus.gnt, 3'b000);
        tick();

        // Load DEADBEEF at 0x005 through requester 0
        drive(0, 4'hF, 9'h005, 32'hDEADBEEF);
        bus.req = 3'b001;
        @(negedge clk); chk("pre_gnt", bus.gnt, 3'b001);
        tick();

        // Write path drive, same cycle
        drive(0, 4'hF, 9'h010, 32'h12345678);
        @(negedge clk);
        chk("wr_en",   bram_en,   1'b1);
        chk("wr_we",   bram_we,   4'hF);
        chk("wr_addr", bram_addr, 9'h010);
        chk("wr_din",  bram_din,  32'h12345678);
        tick();
        bus.req = '0;
        @(negedge clk);
        chk("wr_no_rvalid", bus.rvalid, 3'b000);
        chk("nogrant_en",   bram_en,    1'b0);
        chk("nogrant_we",   bram_we,    4'h0);
        chk("nogrant_addr", bram_addr,  9'h000);
        chk("nogrant_din",  bram_din,   32'h0);
        tick();

        // Requester 1 reads 0x005
        drive(0, 4'h0, 9'h000, 32'h0);
        drive(1, 4'h0, 9'h005, 32'h0);
        bus.req = 3'b010;
        @(negedge clk);
        chk("rd_gnt",  bus.gnt,   3'b010);
        chk("rd_addr", bram_addr, 9'h005);
        chk("rd_we",   bram_we,   4'h0);
        tick();
        bus.req = '0;
        @(negedge clk);
        chk("rd_rvalid", bus.rvalid, 3'b010);
        chk("rd_rdata",  bus.rdata,  32'hDEADBEEF);
        tick();
        @(negedge clk);
        chk("rd_rvalid_off", bus.rvalid, 3'b000);
        chk("rd_rdata_off",  bus.rdata,  32'h0);
        tick();

        // Requester 2 reads back the word written at 0x010
        drive(2, 4'h0, 9'h010, 32'h0);
        bus.req = 3'b100;
        @(negedge clk); chk("rb_gnt", bus.gnt, 3'b100);
        tick();
        bus.req = '0;
        @(negedge clk);
        chk("rb_rvalid", bus.rvalid, 3'b100);
        chk("rb_rdata",  bus.rdata,  32'h12345678);
        tick();

        // Locked burst by requester 2, then requester 0 waits
        bus.req  = 3'b100;
        bus.lock = 3'b100;
        @(negedge clk); chk("lock_first", bus.gnt, 3'b100);
        tick();
        bus.req = 3'b101;
`ifdef BRAM_ARB_HOLD_LIMIT_EN
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk($sformatf("hold_%0d", k), bus.gnt, 3'b100);
            tick();
        end
        @(negedge clk); chk("hold_release", bus.gnt, 3'b001);
        tick();
        @(negedge clk); chk("relock", bus.gnt, 3'b100);
        tick();
`else
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); chk($sformatf("hold_%0d", k), bus.gnt, 3'b100);
            tick();
        end
`endif
        // Owner drops req: pointer sits at 2, so requester 0 wins at once
        bus.req  = 3'b001;
        bus.lock = '0;
        @(negedge clk); chk("owner_drop", bus.gnt, 3'b001);
        tick();

        // Reset asserted right after a granted read
        drive(1, 4'h0, 9'h005, 32'h0);
        bus.req = 3'b010;
        @(negedge clk); chk("mid_gnt", bus.gnt, 3'b010);
        #1 rst_n = 1'b0;
        #1 chk("mid_rst_gnt", bus.gnt, 3'b000);
        @(posedge clk); #1;
        chk("mid_rst_rvalid", bus.rvalid, 3'b000);
        chk("mid_rst_rdata",  bus.rdata,  32'h0);
        bus.req = '0;
        tick();
        rst_n = 1'b1;
        @(negedge clk); chk("post_rst_rvalid", bus.rvalid, 3'b000);
        tick();
        bus.req = 3'b111;
        @(negedge clk); chk("post_rst_rr", bus.gnt, 3'b001);
        tick();
        bus.req = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
